// File: rtl/zapper_seq_pkg.sv
// zapper_seq_pkg: sequencer state encoding and the active-duck search helper.
package zapper_seq_pkg;
    localparam int STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {IDLE, ARM, BLACK, TARGET, COOL} state_t;
    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } duck_pick_t;
    // Lowest set bit of mask at or above position from.
    function automatic duck_pick_t next_duck(input logic [3:0] mask, input logic [2:0] from);
        duck_pick_t p;
        p = '0;
        for (int i = 3; i >= 0; i--)
            if (mask[i] && 3'(i) >= from) p = '{1'b1, 2'(i)};
        return p;
    endfunction
endpackage

// File: rtl/zapper_seq_if.sv
// zapper_seq_if: gun inputs, overlay controls and duck shot outputs of the sequencer.
interface zapper_seq_if #(parameter int NUM_DUCKS = 2);
    logic                 vsync, trigger, sensor, new_round;
    logic [NUM_DUCKS-1:0] duck_active, hit;
    logic                 blank_frame, target_en, miss, busy;
    logic [1:0]           target_sel, shots_left;
    modport master(output vsync, trigger, sensor, duck_active, new_round,
                   input blank_frame, target_en, target_sel, hit, miss, shots_left, busy);
    modport slave(input vsync, trigger, sensor, duck_active, new_round,
                  output blank_frame, target_en, target_sel, hit, miss, shots_left, busy);
endinterface

// File: rtl/zapper_seq_light_meter.sv
// zapper_seq_light_meter: synchronises the photodiode and flags a frame in which
// the sensor stayed lit for MIN_LIT consecutive cycles.
module zapper_seq_light_meter #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_LIT     = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sensor,
    input  logic frame_tick,
    output logic light_seen
);
    localparam int CW = $clog2(MIN_LIT + 1);
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          lit_cnt;
    logic                   lit;
    assign lit = lit_cnt == CW'(MIN_LIT);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sync       <= '0;
            lit_cnt    <= '0;
            light_seen <= 1'b0;
        end else begin
            sync       <= SYNC_STAGES'({sync, sensor});
            lit_cnt    <= (frame_tick || !sync[SYNC_STAGES-1]) ? '0 : lit ? lit_cnt : lit_cnt + CW'(1);
            light_seen <= !frame_tick && (light_seen || lit);
        end
endmodule

// File: rtl/zapper_seq.sv
// zapper_seq: light-gun shot sequencer; runs black/target overlay frames after a
// trigger, judges the photodiode per frame and owns the per-round shot budget.
module zapper_seq
    import zapper_seq_pkg::*;
#(
    parameter int NUM_DUCKS       = 2,
    parameter int SHOTS           = 3,
    parameter int MIN_LIT         = 16,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int SYNC_STAGES     = 2
) (
    input logic        clk,
    input logic        rst_n,
    zapper_seq_if.slave bus
);
    localparam int CCW = $clog2(COOLDOWN_FRAMES) + 1;
    state_t               state, state_n;
    logic [1:0]           idx, idx_n, shots, shots_n;
    logic [CCW-1:0]       cool_cnt, cool_n;
    logic [NUM_DUCKS-1:0] hit_q, hit_n;
    logic                 miss_q, miss_n;
    logic [SYNC_STAGES-1:0] trig_sync;
    logic                 trig_prev, vsync_q, vsync_qq, trig_pulse, frame_tick, light_seen;
    logic [3:0]           act;
    duck_pick_t           first, after;

    assign trig_pulse = trig_sync[SYNC_STAGES-1] && !trig_prev;
    assign frame_tick = vsync_q && !vsync_qq;
    assign act        = 4'(bus.duck_active);
    assign first      = next_duck(act, 3'd0);
    assign after      = next_duck(act, 3'(idx) + 3'd1);

    zapper_seq_light_meter #(.SYNC_STAGES(SYNC_STAGES), .MIN_LIT(MIN_LIT)) u_meter (
        .clk(clk), .rst_n(rst_n), .sensor(bus.sensor), .frame_tick(frame_tick), .light_seen(light_seen)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            cool_cnt  <= '0;
            shots     <= 2'(SHOTS);
            hit_q     <= '0;
            miss_q    <= 1'b0;
            trig_sync <= '0;
            trig_prev <= 1'b0;
            vsync_q   <= 1'b0;
            vsync_qq  <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            cool_cnt  <= cool_n;
            shots     <= shots_n;
            hit_q     <= hit_n;
            miss_q    <= miss_n;
            trig_sync <= SYNC_STAGES'({trig_sync, bus.trigger});
            trig_prev <= trig_sync[SYNC_STAGES-1];
            vsync_q   <= bus.vsync;
            vsync_qq  <= vsync_q;
        end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cool_n  = cool_cnt;
        shots_n = shots;
        hit_n   = '0;
        miss_n  = 1'b0;
        case (state)
            IDLE: if (trig_pulse && shots != '0) begin
                shots_n = shots - 2'd1;
                miss_n  = act == '0;
                state_n = act == '0 ? COOL : ARM;
                cool_n  = '0;
            end
            ARM: if (frame_tick) state_n = BLACK;
            BLACK: if (frame_tick) begin
                miss_n  = light_seen || !first.found;
                state_n = miss_n ? COOL : TARGET;
                idx_n   = first.idx;
                cool_n  = '0;
            end
            TARGET: if (frame_tick) begin
                hit_n   = light_seen ? NUM_DUCKS'(1) << idx : '0;
                miss_n  = !light_seen && !after.found;
                state_n = (light_seen || !after.found) ? COOL : TARGET;
                idx_n   = after.idx;
                cool_n  = '0;
            end
            COOL: if (frame_tick) begin
                cool_n  = cool_cnt + CCW'(1);
                state_n = cool_cnt == CCW'(COOLDOWN_FRAMES - 1) ? IDLE : COOL;
            end
            default: state_n = IDLE;
        endcase
        // A reload wins over a same-cycle decrement and never aborts a sequence.
        if (bus.new_round) shots_n = 2'(SHOTS);
    end

    always_comb begin
        bus.blank_frame = state == BLACK;
        bus.target_en   = state == TARGET;
        bus.target_sel  = state == TARGET ? idx : 2'd0;
        bus.busy        = state != IDLE;
        bus.hit         = hit_q;
        bus.miss        = miss_q;
        bus.shots_left  = shots;
    end
endmodule

// File: tb/tb_zapper_seq.sv
// tb_zapper_seq: directed and randomized shots checked against a frame-level model.
module tb_zapper_seq;
    localparam int ND = 2, SHOTS = 3, MIN_LIT = 16, FRAME = 60;
    logic clk = 1'b0, rst_n = 1'b0;
    int checks = 0, failures = 0, hit_cycles = 0, miss_cnt = 0, shots_m = SHOTS;
    logic [ND-1:0] last_hit = '0;

    zapper_seq_if #(.NUM_DUCKS(ND)) bus();
    zapper_seq #(.NUM_DUCKS(ND), .SHOTS(SHOTS), .MIN_LIT(MIN_LIT), .COOLDOWN_FRAMES(8), .SYNC_STAGES(2))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        bus.vsync = 1'b0;
        forever begin
            repeat (FRAME - 4) @(negedge clk);
            bus.vsync = 1'b1;
            repeat (4) @(negedge clk);
            bus.vsync = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (bus.hit != '0) begin
            hit_cycles++;
            last_hit = bus.hit;
        end
        if (bus.miss) miss_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame();
        @(posedge bus.vsync);
    endtask

    task automatic new_round();
        cyc(1); bus.new_round = 1'b1; cyc(1); bus.new_round = 1'b0; cyc(1);
        shots_m = SHOTS;
        chk("shots_reload", bus.shots_left, shots_m);
    endtask

    // Frame 0 holds the trigger; frame 1 is black, frames 2.. show the active ducks in order.
    task automatic do_shot(input logic [ND-1:0] m, input int s, input int len, input bit bounce);
        int q[$];
        int d, hd, h0, m0, last, sel;
        bit acc, seen, is_hit, te;
        for (int i = 0; i < ND; i++) if (m[i]) q.push_back(i);
        acc    = shots_m != 0;
        seen   = len >= MIN_LIT;
        is_hit = acc && m != '0 && seen && s >= 2 && s - 2 < q.size();
        hd     = is_hit ? q[s-2] : 0;
        d      = !acc ? -9 : m == '0 ? -1 : (seen && s == 1) ? 1 : is_hit ? s : q.size() + 1;
        if (acc) shots_m--;
        h0 = hit_cycles;
        m0 = miss_cnt;
        frame();
        bus.duck_active = m;
        cyc(5); bus.trigger = 1'b1; cyc(6); bus.trigger = 1'b0; cyc(20);
        chk("busy_after_trigger", bus.busy, acc);
        chk("shots_after_trigger", bus.shots_left, shots_m);
        last = acc ? d + 9 : 2;
        for (int f = 1; f <= last; f++) begin
            frame();
            cyc(10);
            if (bounce && f >= d + 2 && f <= d + 4) begin
                bus.trigger = 1'b1; cyc(3); bus.trigger = 1'b0; cyc(17);
            end else if (f == s) begin
                bus.sensor = 1'b1; cyc(len); bus.sensor = 1'b0; cyc(20 - len);
            end else cyc(20);
            cyc(10);
            te  = acc && f >= 2 && f <= d;
            sel = 0;
            if (te) sel = q[f-2];
            chk("blank_frame", bus.blank_frame, acc && f == 1 && d >= 1);
            chk("target_en", bus.target_en, te);
            chk("target_sel", bus.target_sel, sel);
            chk("busy", bus.busy, acc && f <= d + 8);
        end
        chk("hit_cycles", hit_cycles - h0, is_hit);
        if (is_hit) chk("hit_vec", last_hit, 1 << hd);
        chk("miss_pulses", miss_cnt - m0, acc && !is_hit);
        chk("shots_left", bus.shots_left, shots_m);
    endtask

    initial begin
        int h0, m0;
        bus.trigger = 1'b0; bus.sensor = 1'b0; bus.new_round = 1'b0; bus.duck_active = '0;
        cyc(3);
        chk("rst_outputs", {bus.blank_frame, bus.target_en, bus.target_sel, bus.hit, bus.miss, bus.busy}, 0);
        chk("rst_shots", bus.shots_left, SHOTS);
        rst_n = 1'b1;
        cyc(3);

        // Abort in the middle of the first target frame.
        h0 = hit_cycles; m0 = miss_cnt;
        frame(); bus.duck_active = 2'b11;
        cyc(5); bus.trigger = 1'b1; cyc(6); bus.trigger = 1'b0;
        frame(); frame(); cyc(40);
        chk("pre_rst_target_en", bus.target_en, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", {bus.blank_frame, bus.target_en, bus.target_sel, bus.hit, bus.miss, bus.busy}, 0);
        chk("async_rst_shots", bus.shots_left, SHOTS);
        cyc(2); rst_n = 1'b1;
        shots_m = SHOTS;
        repeat (3) frame();
        cyc(30);
        chk("post_rst_busy", bus.busy, 0);
        chk("post_rst_shots", bus.shots_left, SHOTS);
        chk("post_rst_pulses", (hit_cycles - h0) + (miss_cnt - m0), 0);

        // Budget exhaustion: three ambient misses, then a refused fourth trigger.
        for (int i = 0; i < 3; i++) do_shot(ND'($urandom_range(1, 3)), 1, 20, 1'b0);
        do_shot(2'b11, 3, 20, 1'b0);
        new_round();

        do_shot(2'b11, 3, 20, 1'b0);   // hit on the second duck
        do_shot(2'b11, 1, 20, 1'b0);   // light during the black frame
        new_round();
        do_shot(2'b01, 2, 10, 1'b0);   // glitch shorter than MIN_LIT
        do_shot(2'b10, 0, 20, 1'b1);   // bouncing trigger during cooldown
        do_shot(2'b01, 2, 20, 1'b0);   // next trigger accepted once idle

        for (int i = 0; i < 8; i++) begin
            if (shots_m == 0) new_round();
            do_shot(ND'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                    $urandom_range(0, 1) != 0 ? 20 : 10, $urandom_range(0, 1) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
